// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MEM-stage data memory access controller and the
// main decoder that feeds it.
//   state_t        : access controller FSM states
//   ERR_*          : err_code values reported alongside the err pulse
//   OP_LW / OP_SW  : load/store word opcodes, shared with the decoder
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2B;

    // A word access is legal only on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl_if
// Request/acknowledge bus between the access controller and data memory.
//   mem_req    : request, held until mem_ack
//   mem_we     : 1 = write, 0 = read; stable while mem_req
//   mem_addr   : word-aligned byte address; stable while mem_req
//   mem_wdata  : store data; stable while mem_req
//   mem_ack    : completion from memory
//   mem_rdata  : read data, valid with mem_ack on reads
// master = controller side, slave = memory side.
// -----------------------------------------------------------------------------
interface dmem_access_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
// Consumer of the decoder MemRead/MemWrite controls. Turns a MEM-stage load or
// store into a req/ack transaction with variable-latency data memory, stalls
// the pipeline until it completes and returns load data. Misaligned, illegal
// (read and write together) and timed-out accesses raise a one-cycle err.
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   MemRead    : load request
//   MemWrite   : store request
//   addr       : byte address from the ALU
//   wdata      : store data
//   rdata      : last load result, held until the next load completes
//   stall      : freeze PC/IF/ID/EX/MEM registers
//   err        : one-cycle error pulse
//   err_code   : 01 misaligned, 10 read+write, 11 timeout; holds last value
//   mem        : memory bus (master side)
// -----------------------------------------------------------------------------
module dmem_access_ctrl
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              err,
    output logic [1:0]        err_code,
    dmem_access_ctrl_if.master mem
);

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              accept;
    logic              rdata_ld;
    logic              err_set;
    logic [1:0]        err_code_n;
    logic              rq;

    assign rq = MemRead | MemWrite;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and control
    // -------------------------------------------------------------------------
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        stall      = 1'b0;
        accept     = 1'b0;
        rdata_ld   = 1'b0;
        err_set    = 1'b0;
        err_code_n = err_code;

        unique case (state)
            IDLE: begin
                cnt_n = '0;
                // Illegal is checked before alignment so it wins when both apply.
                if (MemRead && MemWrite) begin
                    err_set    = 1'b1;
                    err_code_n = ERR_ILLEGAL;
                end else if (rq && is_misaligned(addr[1:0])) begin
                    err_set    = 1'b1;
                    err_code_n = ERR_MISALIGN;
                end else if (rq) begin
                    // Stall must rise in this same cycle so the pipeline does
                    // not advance past the load/store before it is serviced.
                    stall   = 1'b1;
                    accept  = 1'b1;
                    state_n = REQ;
                end
            end

            REQ: begin
                stall = 1'b1;
                cnt_n = cnt + CNT_W'(1);
                // An ack on the last allowed cycle still counts as success.
                if (mem.mem_ack) begin
                    rdata_ld = !we_q;
                    state_n  = DONE;
                    cnt_n    = '0;
                end else if (cnt == CNT_LAST) begin
                    err_set    = 1'b1;
                    err_code_n = ERR_TIMEOUT;
                    state_n    = DONE;
                    cnt_n      = '0;
                end
            end

            DONE: begin
                // Pipeline advances on this edge; the instruction still on the
                // inputs is the one just serviced, so nothing is accepted here.
                cnt_n   = '0;
                state_n = IDLE;
            end

            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Latched request, load data and error reporting
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata    <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            if (accept) begin
                we_q    <= MemWrite;
                addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                wdata_q <= wdata;
            end
            if (rdata_ld) begin
                rdata <= mem.mem_rdata;
            end
            err <= err_set;
            if (err_set) begin
                err_code <= err_code_n;
            end
        end
    end

    // Request is a pure state decode so reset removes it without waiting for
    // a clock edge.
    assign mem.mem_req   = (state == REQ);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

endmodule
